// File: rtl/dcollide_pkg.sv
// Shared types and width helpers for the sphere batch collision engine.
package dcollide_pkg;

  typedef enum logic [2:0] {
    IDLE, LOAD, MX, MY, MZ, MR, CMP, DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_X, OP_Y, OP_Z, OP_R
  } op_sel_t;

  localparam int CYC_PER_SLOT = 6;

  // Difference of two signed words, product of two differences, and a sum of three products.
  function automatic int d_w(input int w);
    return w + 1;
  endfunction

  function automatic int prod_w(input int w);
    return 2 * w + 2;
  endfunction

  function automatic int acc_w(input int w);
    return 2 * w + 4;
  endfunction

endpackage

// File: rtl/dcollide_sq_acc.sv
// Single shared squarer with a clear/accumulate register for d^2 and a
// separate result register for the squared radius sum.
module dcollide_sq_acc
  import dcollide_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  op_sel_t                        op_sel,
  input  logic                           acc_clr,
  input  logic                           acc_en,
  input  logic signed [d_w(WIDTH)-1:0]   dx,
  input  logic signed [d_w(WIDTH)-1:0]   dy,
  input  logic signed [d_w(WIDTH)-1:0]   dz,
  input  logic        [d_w(WIDTH)-1:0]   rs,
  output logic        [acc_w(WIDTH)-1:0] acc,
  output logic        [prod_w(WIDTH)-1:0] rr
);
  localparam int DW = d_w(WIDTH);
  localparam int PW = prod_w(WIDTH);
  localparam int AW = acc_w(WIDTH);

  logic signed [DW-1:0] d_sel;
  logic        [DW-1:0] op;
  logic        [PW-1:0] prod;

  // Square the magnitude so one unsigned multiplier serves both d^2 and rs^2.
  always_comb begin
    d_sel = dx;
    case (op_sel)
      OP_Y:    d_sel = dy;
      OP_Z:    d_sel = dz;
      default: d_sel = dx;
    endcase
    op = d_sel[DW-1] ? $unsigned(-d_sel) : $unsigned(d_sel);
    if (op_sel == OP_R) op = rs;
  end

  assign prod = PW'(op) * PW'(op);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      rr  <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (acc_en) begin
      if (op_sel == OP_R) rr <= prod;
      else                acc <= acc + AW'(prod);
    end
  end

endmodule

// File: rtl/dcollide_sphere_batch.sv
// Tests one query sphere against every stored slot, six cycles per slot,
// and reports hit mask/count/first index with a done pulse.
module dcollide_sphere_batch
  import dcollide_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FRAC      = 16,
  parameter int NUM_SLOTS = 4,
  parameter int IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_addr,
  input  logic signed [WIDTH-1:0] wr_x,
  input  logic signed [WIDTH-1:0] wr_y,
  input  logic signed [WIDTH-1:0] wr_z,
  input  logic [WIDTH-1:0]        wr_r,
  input  logic                    clr_valid,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] qx,
  input  logic signed [WIDTH-1:0] qy,
  input  logic signed [WIDTH-1:0] qz,
  input  logic [WIDTH-1:0]        qr,
  output logic                    busy,
  output logic                    done,
  output logic                    ret,
  output logic [NUM_SLOTS-1:0]    hit_mask,
  output logic [IDX_W:0]          hit_count,
  output logic [IDX_W-1:0]        first_hit_idx
);
  localparam int DW = d_w(WIDTH);
  localparam int PW = prod_w(WIDTH);
  localparam int AW = acc_w(WIDTH);

  if (NUM_SLOTS < 1 || NUM_SLOTS > 64 || FRAC < 0 || FRAC >= WIDTH) begin : g_bad_param
    $error("dcollide_sphere_batch: parameter out of range");
  end

  logic signed [WIDTH-1:0] slot_x [NUM_SLOTS];
  logic signed [WIDTH-1:0] slot_y [NUM_SLOTS];
  logic signed [WIDTH-1:0] slot_z [NUM_SLOTS];
  logic        [WIDTH-1:0] slot_r [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]    valid;

  state_t                  state, state_n;
  op_sel_t                 op_sel;
  logic                    acc_clr, acc_en;
  logic [IDX_W-1:0]        idx;
  logic signed [WIDTH-1:0] q_x, q_y, q_z;
  logic        [WIDTH-1:0] q_r;
  logic signed [DW-1:0]    dx, dy, dz;
  logic        [DW-1:0]    rs;
  logic        [AW-1:0]    acc;
  logic        [PW-1:0]    rr;
  logic                    last, hit, wr_ok;

  assign busy  = (state != IDLE) && (state != DONE);
  assign done  = (state == DONE);
  assign last  = (idx == IDX_W'(NUM_SLOTS - 1));
  assign hit   = valid[idx] && (acc <= AW'(rr));
  assign wr_ok = wr_en && !busy && ({1'b0, wr_addr} < (IDX_W+1)'(NUM_SLOTS));

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      slot_x[wr_addr] <= wr_x;
      slot_y[wr_addr] <= wr_y;
      slot_z[wr_addr] <= wr_z;
      slot_r[wr_addr] <= wr_r;
    end
  end

  // A write to a slot overrides a simultaneous clear for that slot only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (!busy) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (wr_ok && wr_addr == IDX_W'(s)) valid[s] <= 1'b1;
        else if (clr_valid)                valid[s] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    op_sel  = OP_X;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    case (state)
      IDLE: if (start) state_n = LOAD;
      LOAD: begin state_n = MX;  acc_clr = 1'b1; end
      MX:   begin state_n = MY;  acc_en = 1'b1; op_sel = OP_X; end
      MY:   begin state_n = MZ;  acc_en = 1'b1; op_sel = OP_Y; end
      MZ:   begin state_n = MR;  acc_en = 1'b1; op_sel = OP_Z; end
      MR:   begin state_n = CMP; acc_en = 1'b1; op_sel = OP_R; end
      CMP:  state_n = last ? DONE : LOAD;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx           <= '0;
      q_x           <= '0;
      q_y           <= '0;
      q_z           <= '0;
      q_r           <= '0;
      dx            <= '0;
      dy            <= '0;
      dz            <= '0;
      rs            <= '0;
      hit_mask      <= '0;
      hit_count     <= '0;
      first_hit_idx <= '0;
      ret           <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          q_x           <= qx;
          q_y           <= qy;
          q_z           <= qz;
          q_r           <= qr;
          idx           <= '0;
          hit_mask      <= '0;
          hit_count     <= '0;
          first_hit_idx <= '0;
          ret           <= 1'b0;
        end
        LOAD: begin
          dx <= DW'(slot_x[idx]) - DW'(q_x);
          dy <= DW'(slot_y[idx]) - DW'(q_y);
          dz <= DW'(slot_z[idx]) - DW'(q_z);
          rs <= DW'(q_r) + DW'(slot_r[idx]);
        end
        CMP: begin
          if (hit) begin
            hit_mask[idx] <= 1'b1;
            hit_count     <= hit_count + 1'b1;
            if (hit_count == '0) first_hit_idx <= idx;
          end
          if (last) ret <= hit || (hit_count != '0);
          else      idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  dcollide_sq_acc #(.WIDTH(WIDTH)) u_sq_acc (
    .clk     (clk),
    .rst     (rst),
    .op_sel  (op_sel),
    .acc_clr (acc_clr),
    .acc_en  (acc_en),
    .dx      (dx),
    .dy      (dy),
    .dz      (dz),
    .rs      (rs),
    .acc     (acc),
    .rr      (rr)
  );

endmodule
